uart_tx_arbiter: RTL and testbench

- Shares one UART transmitter between NUM_REQ button-driven requesters.
- Each requester delivers a one-cycle request pulse, normally from a debounced single-pulse generator, together with a data byte.
- The block latches pending requests, picks one round-robin, issues a one-cycle tx_start with the byte, and tracks tx_busy to completion before the next grant.
- Sits between the button front-end and the uart_tx core.

---
 rtl/uart_tx_arbiter.sv | 149 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx core among NUM_REQ pulse-driven requesters. Round-robin by default.
// Define UART_ARB_FIXED_PRIO_EN for fixed priority, where the lowest pending index wins.
`timescale 1ns/1ps
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned IDX_W   = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_pulse,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic                      tx_busy,
    input  logic                      clr_ovr,
    output logic                      tx_start,
    output logic [DATA_W-1:0]         tx_data,
    output logic [IDX_W-1:0]          grant_id,
    output logic                      active,
    output logic [NUM_REQ-1:0]        pending,
    output logic [NUM_REQ-1:0]        overrun
);

    localparam int unsigned SEL_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [3:0] {
        S_IDLE      = 4'b0001,
        S_START     = 4'b0010,
        S_WAIT_ACK  = 4'b0100,
        S_WAIT_DONE = 4'b1000
    } state_t;

    state_t                         r_state, w_state_nxt;
    logic [NUM_REQ-1:0]             r_pending, r_overrun, w_clr, w_ovr_set;
    logic [NUM_REQ-1:0][DATA_W-1:0] r_buf, w_buf_nxt;
    logic [IDX_W-1:0]               r_win, w_winner, r_grant_id, w_grant_id_nxt;
    logic [DATA_W-1:0]              r_tx_data, w_tx_data_nxt;
    logic                           r_tx_start, w_tx_start_nxt, r_active, w_active_nxt;
    logic                           w_found, w_load;
    logic [3:0]                     r_ack_cnt;

`ifdef UART_ARB_FIXED_PRIO_EN
    // Lowest pending index wins.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!w_found && r_pending[SEL_W'(k)]) begin
                w_found  = 1'b1;
                w_winner = IDX_W'(k);
            end
        end
    end
`else
    logic [IDX_W-1:0] r_ptr;
    int unsigned      w_idx;

    // First pending index at or after the pointer, wrapping modulo NUM_REQ.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            w_idx = 32'(r_ptr) + k;
            if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
            if (!w_found && r_pending[SEL_W'(w_idx)]) begin
                w_found  = 1'b1;
                w_winner = IDX_W'(w_idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 r_ptr <= '0;
        else if (r_state == S_START) r_ptr <= (r_win == IDX_W'(NUM_REQ - 1)) ? '0 : r_win + IDX_W'(1);
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:      if (w_found && !tx_busy) w_state_nxt = S_START;
            S_START:     w_state_nxt = S_WAIT_ACK;
            S_WAIT_ACK:  if (tx_busy) w_state_nxt = S_WAIT_DONE;
                         else if (r_ack_cnt == 4'd15) w_state_nxt = S_IDLE;
            S_WAIT_DONE: if (!tx_busy) w_state_nxt = S_IDLE;
            default:     w_state_nxt = S_IDLE;
        endcase
    end

    // Next values of the registered outputs, decoded from the upcoming state.
    always_comb begin
        w_load          = (r_state == S_IDLE) && (w_state_nxt == S_START);
        w_tx_start_nxt  = (w_state_nxt == S_START);
        w_active_nxt    = (w_state_nxt != S_IDLE);
        w_tx_data_nxt   = r_tx_data;
        w_grant_id_nxt  = r_grant_id;
        if (w_load) begin
            w_tx_data_nxt  = r_buf[SEL_W'(w_winner)];
            w_grant_id_nxt = w_winner;
        end
    end

    // A same-cycle pulse beats the serve clear, and is not an overrun.
    always_comb begin
        w_clr     = (r_state == S_START) ? (NUM_REQ'(1) << r_win) : '0;
        w_ovr_set = req_pulse & r_pending & ~w_clr;
        w_buf_nxt = r_buf;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (req_pulse[SEL_W'(i)]) w_buf_nxt[SEL_W'(i)] = req_data[i*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending  <= '0;
            r_overrun  <= '0;
            r_buf      <= '0;
            r_win      <= '0;
            r_ack_cnt  <= '0;
            r_tx_start <= 1'b0;
            r_active   <= 1'b0;
            r_tx_data  <= '0;
            r_grant_id <= '0;
        end else begin
            r_pending  <= (r_pending & ~w_clr) | req_pulse;
            r_overrun  <= (clr_ovr ? '0 : r_overrun) | w_ovr_set;
            r_buf      <= w_buf_nxt;
            if (w_load) r_win <= w_winner;
            r_ack_cnt  <= (r_state == S_WAIT_ACK) ? r_ack_cnt + 4'd1 : 4'd0;
            r_tx_start <= w_tx_start_nxt;
            r_active   <= w_active_nxt;
            r_tx_data  <= w_tx_data_nxt;
            r_grant_id <= w_grant_id_nxt;
        end
    end

    assign tx_start = r_tx_start;
    assign tx_data  = r_tx_data;
    assign grant_id = r_grant_id;
    assign active   = r_active;
    assign pending  = r_pending;
    assign overrun  = r_overrun;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: directed corner cases plus randomized request bursts.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

    localparam int NREQ  = 4;
    localparam int FRAME = 10;

    logic        clk, rst_n;
    logic [3:0]  req_pulse;
    logic [31:0] req_data;
    logic        tx_busy, clr_ovr, fb;
    logic        tx_start, active;
    logic [7:0]  tx_data;
    logic [1:0]  grant_id;
    logic [3:0]  pending, overrun;
    int          ub_cnt;

    typedef struct { int id; int data; } exp_t;
    exp_t exp_q[$];
    int   n_checks, n_errors, m_ptr;

    uart_tx_arbiter #(.NUM_REQ(4), .DATA_W(8), .IDX_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .req_pulse(req_pulse), .req_data(req_data),
        .tx_busy(tx_busy), .clr_ovr(clr_ovr), .tx_start(tx_start), .tx_data(tx_data),
        .grant_id(grant_id), .active(active), .pending(pending), .overrun(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Simple uart_tx stand-in: busy for FRAME cycles starting the cycle after tx_start.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)          ub_cnt <= 0;
        else if (tx_start)   ub_cnt <= FRAME;
        else if (ub_cnt != 0) ub_cnt <= ub_cnt - 1;
    end
    assign tx_busy = (ub_cnt != 0) | fb;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected frames are queued in serve order; the arbiter pointer follows the last served id.
    task automatic push_exp(input int id, input int data);
        exp_t e;
        e.id   = id;
        e.data = data;
        exp_q.push_back(e);
`ifndef UART_ARB_FIXED_PRIO_EN
        m_ptr = (id + 1) % NREQ;
`endif
    endtask

    task automatic pulse(input logic [3:0] mask, input logic [31:0] bytes, input logic clr);
        req_pulse = mask;
        req_data  = bytes;
        clr_ovr   = clr;
        tick();
        req_pulse = '0;
        clr_ovr   = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (!(pending == 0 && !active && !tx_busy) && n < budget) begin
            tick();
            n++;
        end
        check("idle_timeout", int'(n < budget), 1);
    endtask

    task automatic wait_start(input int budget);
        int n = 0;
        while (!tx_start && n < budget) begin
            tick();
            n++;
        end
        check("start_timeout", int'(n < budget), 1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        m_ptr = 0;
        tick();
    endtask

    task automatic monitor();
        int   act_len;
        exp_t e;
        act_len = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                act_len = 0;
            end else begin
                if (tx_start) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_start: grant %0d data 0x%0h with no frame expected", grant_id, tx_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("grant_id", int'(grant_id), e.id);
                        check("tx_data", int'(tx_data), e.data);
                        check("active_at_start", int'(active), 1);
                    end
                end
                if (active) act_len++;
                else if (act_len != 0) begin
                    check("active_len", act_len, 1 + 1 + FRAME);
                    act_len = 0;
                end
            end
        end
    endtask

    initial begin
        int          seen;
        logic [3:0]  m;
        logic [31:0] bytes;
        int          base, idx;
        bit          found;

        n_checks = 0; n_errors = 0; m_ptr = 0;
        rst_n = 1'b0; req_pulse = '0; req_data = '0; clr_ovr = 1'b0; fb = 1'b0;
        fork monitor(); join_none
        tick();
        check("reset_outputs", int'({tx_start, active, pending, overrun, grant_id, tx_data}), 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Single request on an idle bus: tx_start two cycles after the pulse.
        push_exp(0, 8'h41);
        pulse(4'b0001, 32'h0000_0041, 1'b0);
        check("latency_early", int'(tx_start), 0);
        tick();
        check("latency_start", int'(tx_start), 1);
        wait_idle(100);
        check("pending_cleared", int'(pending), 0);

        // Three simultaneous requests from pointer 0.
        do_reset();
        push_exp(0, 8'h30);
        push_exp(1, 8'h31);
        push_exp(3, 8'h33);
        pulse(4'b1011, 32'h3300_3130, 1'b0);
        wait_idle(200);
        check("burst_drained", exp_q.size(), 0);

        // Re-request in the START cycle survives the serve clear without overrun.
        push_exp(1, 8'h21);
        pulse(4'b0010, 32'h0000_2100, 1'b0);
        wait_start(20);
        push_exp(1, 8'h77);
        pulse(4'b0010, 32'h0000_7700, 1'b0);
        check("start_rearm_pending", int'(pending), 4'b0010);
        check("start_rearm_overrun", int'(overrun), 0);
        wait_idle(100);

        // A foreign busy blocks arbitration; release gives tx_start one cycle later.
        fb = 1'b1;
        push_exp(0, 8'h10);
        pulse(4'b0001, 32'h0000_0010, 1'b0);
        seen = 0;
        repeat (20) begin
            tick();
            if (tx_start) seen++;
        end
        check("busy_blocks", seen, 0);
        fb = 1'b0;
        tick();
        check("busy_release_start", int'(tx_start), 1);
        wait_idle(100);

        // Overrun: second pulse replaces the byte and sets the sticky flag.
        fb = 1'b1;
        pulse(4'b0100, 32'h0055_0000, 1'b0);
        pulse(4'b0100, 32'h0066_0000, 1'b0);
        check("overrun_set", int'(overrun), 4'b0100);
        check("overrun_pending", int'(pending), 4'b0100);
        push_exp(2, 8'h66);
        fb = 1'b0;
        wait_idle(100);
        check("overrun_sticky", int'(overrun), 4'b0100);
        clr_ovr = 1'b1;
        tick();
        clr_ovr = 1'b0;
        check("overrun_clr", int'(overrun), 0);

        // An overrun event in the same cycle as clr_ovr wins.
        fb = 1'b1;
        pulse(4'b0100, 32'h0012_0000, 1'b0);
        pulse(4'b0100, 32'h0013_0000, 1'b1);
        check("overrun_beats_clr", int'(overrun), 4'b0100);
        push_exp(2, 8'h13);
        fb = 1'b0;
        wait_idle(100);
        pulse(4'b0000, 32'h0, 1'b1);
        check("overrun_clr2", int'(overrun), 0);

        // Reset in the middle of a frame.
        push_exp(3, 8'h99);
        pulse(4'b1000, 32'h9900_0000, 1'b0);
        wait_start(20);
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", int'({tx_start, active, pending, overrun, grant_id, tx_data}), 0);
        tick();
        tick();
        rst_n = 1'b1;
        m_ptr = 0;
        seen = 0;
        repeat (20) begin
            tick();
            if (tx_start) seen++;
        end
        check("no_stale_start", seen, 0);

        // Randomized bursts on an idle bus, ordered by the reference arbitration rule.
        repeat (20) begin
            m     = 4'($urandom_range(1, 15));
            bytes = $urandom;
            req_data = bytes;
            for (logic [3:0] rem = m; rem != 0; ) begin
`ifdef UART_ARB_FIXED_PRIO_EN
                base = 0;
`else
                base = m_ptr;
`endif
                found = 1'b0;
                for (int k = 0; k < NREQ; k++) begin
                    idx = (base + k) % NREQ;
                    if (!found && rem[idx]) begin
                        found = 1'b1;
                        rem[idx] = 1'b0;
                        push_exp(idx, int'((bytes >> (8 * idx)) & 32'hFF));
                    end
                end
            end
            pulse(m, bytes, 1'b0);
            wait_idle(300);
            check("rand_drained", exp_q.size(), 0);
            check("rand_no_overrun", int'(overrun), 0);
            repeat ($urandom_range(0, 3)) tick();
        end

        repeat (3) tick();
        check("queue_empty_end", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
